// File: rtl/l1_flatten_pkg.sv
// Shared memory-map constants and FSM state type for the layer-1 flatten
// stage; the convolution engine imports the same constants.
package l1_flatten_pkg;

  // Memory select codes on the shared bus
  localparam logic [2:0] CSEL_IDLE    = 3'b000;
  localparam logic [2:0] CSEL_L0_BASE = 3'b001;
  localparam logic [2:0] CSEL_L1_BASE = 3'b011;
  localparam logic [2:0] CSEL_L2      = 3'b101;

  // Default bus geometry (Q4.16 data, 4K-word address space)
  localparam int DW_DEF = 20;
  localparam int AW_DEF = 12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_FIN  = 2'd3
  } state_t;

  // True when v is a positive power of two
  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/l1_flatten_if.sv
// Control handshake plus shared memory bus between the flatten stage
// (master) and the memory / controller side (slave).
interface l1_flatten_if
  import l1_flatten_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
);
  logic          start;
  logic          busy;
  logic          done;
  logic          crd;
  logic [AW-1:0] caddr_rd;
  logic [DW-1:0] cdata_rd;
  logic          cwr;
  logic [AW-1:0] caddr_wr;
  logic [DW-1:0] cdata_wr;
  logic [2:0]    csel;

  modport master (
    input  start, cdata_rd,
    output busy, done, crd, caddr_rd, cwr, caddr_wr, cdata_wr, csel
  );

  modport slave (
    output start, cdata_rd,
    input  busy, done, crd, caddr_rd, cwr, caddr_wr, cdata_wr, csel
  );
endinterface

// File: rtl/l1_flatten.sv
// Layer-1 flatten: reads each layer-1 max-pool map and writes the elements
// channel-interleaved into layer 2 (addr = p*KERNELS + k). One element takes
// a read cycle then a write cycle; data is passed through untouched.
module l1_flatten
  import l1_flatten_pkg::*;
#(
  parameter int KERNELS  = 2,
  parameter int L1_WORDS = 1024,
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF
) (
  input  logic        clk,
  input  logic        reset,
  l1_flatten_if.master bus
);

  localparam int PW = (L1_WORDS > 1) ? $clog2(L1_WORDS) : 1;
  localparam int KW = (KERNELS > 1) ? $clog2(KERNELS) : 1;
  localparam bit K_POW2 = is_pow2(KERNELS);
  localparam logic [PW-1:0] P_LAST = PW'(L1_WORDS - 1);
  localparam logic [KW-1:0] K_LAST = KW'(KERNELS - 1);

  // Registered state, counters and outputs
  state_t        r_state;
  logic [PW-1:0] r_p;
  logic [KW-1:0] r_k;
  logic          r_busy;
  logic          r_done;
  logic          r_crd;
  logic          r_cwr;
  logic [AW-1:0] r_caddr_rd;
  logic [AW-1:0] r_caddr_wr;
  logic [DW-1:0] r_cdata_wr;
  logic [2:0]    r_csel;

  // Next-state values
  state_t        w_state_nxt;
  logic [PW-1:0] w_p_nxt;
  logic [KW-1:0] w_k_nxt;
  logic          w_busy_nxt;
  logic          w_done_nxt;
  logic          w_crd_nxt;
  logic          w_cwr_nxt;
  logic [AW-1:0] w_caddr_rd_nxt;
  logic [AW-1:0] w_caddr_wr_nxt;
  logic [DW-1:0] w_cdata_wr_nxt;
  logic [2:0]    w_csel_nxt;

  logic [AW-1:0] w_wr_addr;
  logic [KW-1:0] w_k_inc;
  logic [PW-1:0] w_p_inc;

  assign w_k_inc = r_k + KW'(1);
  assign w_p_inc = r_p + PW'(1);

  // Layer-2 write address for the current (p, k): a shift/concat when
  // KERNELS is a power of two, otherwise a running write counter.
  generate
    if (KERNELS == 1) begin : g_addr_one
      assign w_wr_addr = AW'(r_p);
    end else if (K_POW2) begin : g_addr_shift
      assign w_wr_addr = AW'({r_p, r_k});
    end else begin : g_addr_cnt
      logic [AW-1:0] r_wcnt;

      // Running write address: cleared on start, advanced after every write
      always_ff @(posedge clk) begin
        if (!reset) begin
          r_wcnt <= {AW{1'b0}};
        end else if ((r_state == ST_IDLE) && bus.start) begin
          r_wcnt <= {AW{1'b0}};
        end else if (r_state == ST_WR) begin
          r_wcnt <= r_wcnt + AW'(1);
        end else begin
          r_wcnt <= r_wcnt;
        end
      end

      assign w_wr_addr = r_wcnt;
    end
  endgenerate

  // Next-state and next-output logic; outputs are computed one cycle ahead
  // so that every bus signal comes straight from a flop.
  always_comb begin
    w_state_nxt    = r_state;
    w_p_nxt        = r_p;
    w_k_nxt        = r_k;
    w_busy_nxt     = r_busy;
    w_done_nxt     = 1'b0;
    w_crd_nxt      = 1'b0;
    w_cwr_nxt      = 1'b0;
    w_caddr_rd_nxt = r_caddr_rd;
    w_caddr_wr_nxt = r_caddr_wr;
    w_cdata_wr_nxt = r_cdata_wr;
    w_csel_nxt     = CSEL_IDLE;

    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_state_nxt    = ST_RD;
          w_busy_nxt     = 1'b1;
          w_p_nxt        = {PW{1'b0}};
          w_k_nxt        = {KW{1'b0}};
          w_crd_nxt      = 1'b1;
          w_csel_nxt     = CSEL_L1_BASE;
          w_caddr_rd_nxt = {AW{1'b0}};
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end

      ST_RD: begin
        // Read data is valid at the end of the read cycle
        w_state_nxt    = ST_WR;
        w_cdata_wr_nxt = bus.cdata_rd;
        w_cwr_nxt      = 1'b1;
        w_csel_nxt     = CSEL_L2;
        w_caddr_wr_nxt = w_wr_addr;
      end

      ST_WR: begin
        if (r_k != K_LAST) begin
          w_state_nxt    = ST_RD;
          w_k_nxt        = w_k_inc;
          w_crd_nxt      = 1'b1;
          w_csel_nxt     = CSEL_L1_BASE + 3'(w_k_inc);
          w_caddr_rd_nxt = AW'(r_p);
        end else if (r_p != P_LAST) begin
          w_state_nxt    = ST_RD;
          w_k_nxt        = {KW{1'b0}};
          w_p_nxt        = w_p_inc;
          w_crd_nxt      = 1'b1;
          w_csel_nxt     = CSEL_L1_BASE;
          w_caddr_rd_nxt = AW'(w_p_inc);
        end else begin
          w_state_nxt = ST_FIN;
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
        end
      end

      ST_FIN: begin
        // start during the done cycle is deliberately dropped
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // State, counter and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_p        <= {PW{1'b0}};
      r_k        <= {KW{1'b0}};
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_crd      <= 1'b0;
      r_cwr      <= 1'b0;
      r_caddr_rd <= {AW{1'b0}};
      r_caddr_wr <= {AW{1'b0}};
      r_cdata_wr <= {DW{1'b0}};
      r_csel     <= CSEL_IDLE;
    end else begin
      r_state    <= w_state_nxt;
      r_p        <= w_p_nxt;
      r_k        <= w_k_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_crd      <= w_crd_nxt;
      r_cwr      <= w_cwr_nxt;
      r_caddr_rd <= w_caddr_rd_nxt;
      r_caddr_wr <= w_caddr_wr_nxt;
      r_cdata_wr <= w_cdata_wr_nxt;
      r_csel     <= w_csel_nxt;
    end
  end

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.crd      = r_crd;
  assign bus.cwr      = r_cwr;
  assign bus.caddr_rd = r_caddr_rd;
  assign bus.caddr_wr = r_caddr_wr;
  assign bus.cdata_wr = r_cdata_wr;
  assign bus.csel     = r_csel;

endmodule

// File: tb/tb_l1_flatten.sv
// Scoreboard bench for l1_flatten: expected layer-2 writes are queued before
// each run, and a negedge monitor pops/compares on every write strobe.
module tb_l1_flatten;

  localparam int KERNELS  = 2;
  localparam int L1_WORDS = 1024;
  localparam int AW       = 12;
  localparam int DW       = 20;
  localparam int DONE_AT  = 2 * KERNELS * L1_WORDS + 1;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic clk;
  logic reset;
  logic start;

  logic [DW-1:0] map0 [L1_WORDS];
  logic [DW-1:0] map1 [L1_WORDS];
  wr_t exp_q[$];

  int n_checks;
  int n_fail;

  l1_flatten_if #(.AW(AW), .DW(DW)) u_if ();

  l1_flatten #(
    .KERNELS (KERNELS),
    .L1_WORDS(L1_WORDS),
    .AW      (AW),
    .DW      (DW)
  ) u_dut (
    .clk  (clk),
    .reset(reset),
    .bus  (u_if.master)
  );

  assign u_if.start = start;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Layer-1 memory model: combinational read data for the selected map
  always_comb begin
    u_if.cdata_rd = '0;
    if (u_if.crd) begin
      case (u_if.csel)
        3'b011:  u_if.cdata_rd = map0[u_if.caddr_rd[9:0]];
        3'b100:  u_if.cdata_rd = map1[u_if.caddr_rd[9:0]];
        default: u_if.cdata_rd = '0;
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Queue every layer-2 write of one full run in issue order
  task automatic push_expect();
    wr_t e;
    for (int i = 0; i < L1_WORDS; i++) begin
      e.addr = AW'(2 * i);
      e.data = map0[i];
      exp_q.push_back(e);
      e.addr = AW'(2 * i + 1);
      e.data = map1[i];
      exp_q.push_back(e);
    end
  endtask

  // Monitor: strobe protocol and scoreboard comparison of every write
  always @(negedge clk) begin
    wr_t got;
    if (u_if.crd || u_if.cwr) begin
      check("strobe_exclusive", 32'(u_if.crd & u_if.cwr), 32'd0);
    end
    if (u_if.crd) begin
      check("rd_csel", 32'((u_if.csel == 3'b011) || (u_if.csel == 3'b100)), 32'd1);
    end
    if (u_if.cwr) begin
      check("wr_csel", 32'(u_if.csel), 32'h5);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write actual addr=0x%0h data=0x%0h expected no write",
                 u_if.caddr_wr, u_if.cdata_wr);
      end else begin
        got = exp_q.pop_front();
        check("wr_addr", 32'(u_if.caddr_wr), 32'(got.addr));
        check("wr_data", 32'(u_if.cdata_wr), 32'(got.data));
      end
    end
    if (!u_if.crd && !u_if.cwr && (reset == 1'b1)) begin
      if (u_if.csel != 3'b000) begin
        check("idle_csel", 32'(u_if.csel), 32'd0);
      end
    end
  end

  // One run: start accepted at the next posedge (already driven when
  // pre_start), optional ignored start pulse and optional mid-run reset.
  task automatic do_run(input bit pre_start, input int ign_at, input int abort_at);
    int cyc;
    bit fin;
    if (!pre_start) begin
      @(negedge clk);
      start = 1'b1;
    end
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0;
    fin = 1'b0;
    while (!fin) begin
      @(negedge clk);
      cyc++;
      start = (ign_at != 0) && (cyc == ign_at);
      if (cyc == 1) begin
        check("first_rd_strobe", 32'(u_if.crd), 32'd1);
        check("first_rd_addr", 32'(u_if.caddr_rd), 32'd0);
        check("first_rd_csel", 32'(u_if.csel), 32'h3);
        check("busy_after_start", 32'(u_if.busy), 32'd1);
      end
      if ((abort_at != 0) && (cyc == abort_at)) begin
        reset = 1'b0;
        @(negedge clk);
        check("abort_ctl", 32'({u_if.busy, u_if.done, u_if.crd, u_if.cwr}), 32'd0);
        check("abort_csel", 32'(u_if.csel), 32'd0);
        exp_q.delete();
        fin = 1'b1;
      end else if (u_if.done) begin
        check("done_cycle", 32'(cyc), 32'(DONE_AT));
        check("busy_in_done", 32'(u_if.busy), 32'd0);
        check("all_writes_seen", 32'(exp_q.size()), 32'd0);
        fin = 1'b1;
      end else if (cyc > DONE_AT + 100) begin
        check("done_timeout", 32'(cyc), 32'(DONE_AT));
        fin = 1'b1;
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    start    = 1'b0;
    for (int i = 0; i < L1_WORDS; i++) begin
      map0[i] = '0;
      map1[i] = '0;
    end

    // Reset for 3 cycles, then idle with start low
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (20) begin
      @(negedge clk);
      check("idle_ctl", 32'({u_if.busy, u_if.done, u_if.crd, u_if.cwr, u_if.csel}), 32'd0);
      check("idle_addr", 32'({u_if.caddr_rd, u_if.caddr_wr}), 32'd0);
      check("idle_data", 32'(u_if.cdata_wr), 32'd0);
    end

    // Run 1: map0[i]=i, map1[i]=0x80000|i
    for (int i = 0; i < L1_WORDS; i++) begin
      map0[i] = 20'(i);
      map1[i] = 20'h80000 | 20'(i);
    end
    push_expect();
    do_run(1'b0, 0, 0);

    // Run 2: negative data at index 5, start during FIN (ignored),
    // still high the next cycle (accepted), extra start at cycle 100
    map0[5] = 20'hFFFFF;
    map1[5] = 20'h80000;
    push_expect();
    check("exp_l2_10", 32'(exp_q[10].data), 32'hFFFFF);
    check("exp_l2_11", 32'(exp_q[11].data), 32'h80000);
    start = 1'b1;
    @(negedge clk);
    check("fin_start_ignored", 32'(u_if.busy), 32'd0);
    do_run(1'b1, 100, 0);

    // Run 3: reset at cycle 1500, then no writes while idle
    for (int i = 0; i < L1_WORDS; i++) begin
      map0[i] = 20'(i * 3);
      map1[i] = ~20'(i);
    end
    push_expect();
    do_run(1'b0, 0, 1500);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (20) begin
      @(negedge clk);
      check("post_abort_idle", 32'({u_if.busy, u_if.crd, u_if.cwr}), 32'd0);
    end

    // Run 4: fresh flatten after the abort starts again from p=0
    for (int i = 0; i < L1_WORDS; i++) begin
      map0[i] = 20'(i) ^ 20'h5A5A5;
      map1[i] = 20'hC0000 + 20'(i);
    end
    push_expect();
    do_run(1'b0, 0, 0);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
